// File: rtl/remote_node_initiator_if.sv
// rtl/remote_node_initiator_if.sv - request/return channel bundle between initiator and responder
interface remote_node_initiator_if #(
    parameter int width_p     = 32,
    parameter int tag_width_p = 3
);
    logic               v_o;
    logic [width_p-1:0] data_o;
    logic               yumi_i;
    logic               v_i;
    logic [width_p-1:0] data_i;
    logic               yumi_o;

    modport master (
        output v_o, data_o, yumi_o,
        input  yumi_i, v_i, data_i
    );

    modport slave (
        input  v_o, data_o, yumi_o,
        output yumi_i, v_i, data_i
    );
endinterface

// File: rtl/remote_node_initiator.sv
// rtl/remote_node_initiator.sv - tagged request issuer and out-of-order return checker; REMOTE_NODE_INITIATOR_THROTTLE_EN adds LFSR return hold-off
module remote_node_initiator #(
    parameter int width_p     = 32,
    parameter int tag_width_p = 3,
    parameter int num_trans_p = 64
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   en_i,
    remote_node_initiator_if.master bus,
    output logic [tag_width_p:0]   outstanding_o,
    output logic                   done_o,
    output logic [1:0]             error_o
);
    localparam int slots_lp  = 1 << tag_width_p;
    localparam int seq_w_lp  = width_p - tag_width_p;
    localparam int sent_w_lp = $clog2(num_trans_p + 1);

    localparam logic [sent_w_lp-1:0]   num_trans_lp = sent_w_lp'(num_trans_p);
    localparam logic [sent_w_lp-1:0]   sent_one_lp  = sent_w_lp'(1);
    localparam logic [tag_width_p:0]   out_one_lp   = (tag_width_p + 1)'(1);
    localparam logic [tag_width_p-1:0] tag_one_lp   = tag_width_p'(1);
    localparam logic [seq_w_lp-1:0]    seq_one_lp   = seq_w_lp'(1);

    logic [slots_lp-1:0]    busy_r, busy_n;
    logic [width_p-1:0]     mem_r [slots_lp];
    logic [tag_width_p-1:0] tag_r;
    logic [seq_w_lp-1:0]    seq_r;
    logic [sent_w_lp-1:0]   sent_r, sent_n;
    logic [tag_width_p:0]   outstanding_r, outstanding_n;
    logic [1:0]             error_r;
    logic                   done_r;

    logic                   issue;
    logic                   ret;
    logic                   ret_hit;
    logic                   ret_miss;
    logic                   mismatch;
    logic [tag_width_p-1:0] ret_tag;

    // Outputs are gated by reset so nothing leaks while the flops are being cleared.
    assign bus.v_o    = ~reset_i & en_i & (sent_r < num_trans_lp) & ~busy_r[tag_r];
    assign bus.data_o = {seq_r, tag_r};

`ifdef REMOTE_NODE_INITIATOR_THROTTLE_EN
    logic [15:0] lfsr_r;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
        end
    end

    assign bus.yumi_o = ~reset_i & bus.v_i & lfsr_r[0];
`else
    assign bus.yumi_o = ~reset_i & bus.v_i;
`endif

    assign issue    = bus.v_o & bus.yumi_i;
    assign ret      = bus.yumi_o;
    assign ret_tag  = bus.data_i[tag_width_p-1:0];
    assign ret_hit  = ret & busy_r[ret_tag];
    assign ret_miss = ret & ~busy_r[ret_tag];
    assign mismatch = ret_hit & (bus.data_i != mem_r[ret_tag]);

    // Issue and return never target the same slot: issue needs it idle, a hit needs it busy.
    always_comb begin
        busy_n        = busy_r;
        sent_n        = sent_r;
        outstanding_n = outstanding_r;
        if (ret_hit) begin
            busy_n[ret_tag] = 1'b0;
        end
        if (issue) begin
            busy_n[tag_r] = 1'b1;
            sent_n        = sent_r + sent_one_lp;
        end
        case ({issue, ret_hit})
            2'b10:   outstanding_n = outstanding_r + out_one_lp;
            2'b01:   outstanding_n = outstanding_r - out_one_lp;
            default: outstanding_n = outstanding_r;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            busy_r        <= '0;
            tag_r         <= '0;
            seq_r         <= '0;
            sent_r        <= '0;
            outstanding_r <= '0;
            error_r       <= '0;
            done_r        <= 1'b0;
        end else begin
            busy_r        <= busy_n;
            sent_r        <= sent_n;
            outstanding_r <= outstanding_n;
            done_r        <= (sent_n == num_trans_lp) && (outstanding_n == '0);
            if (issue) begin
                tag_r <= tag_r + tag_one_lp;
                seq_r <= seq_r + seq_one_lp;
            end
            if (ret_miss) begin
                error_r[0] <= 1'b1;
            end
            if (mismatch) begin
                error_r[1] <= 1'b1;
            end
        end
    end

    // Copies of issued words are only read for busy slots, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (issue) begin
            mem_r[tag_r] <= bus.data_o;
        end
    end

    assign outstanding_o = outstanding_r;
    assign done_o        = done_r;
    assign error_o       = error_r;
endmodule

// File: tb/tb_remote_node_initiator.sv
// tb/tb_remote_node_initiator.sv - directed bench for remote_node_initiator
module tb_remote_node_initiator;
    logic clk = 1'b0;
    logic rst_a, rst_b, en_a, en_b;
    logic [3:0] outst_a, outst_b;
    logic       done_a, done_b;
    logic [1:0] err_a, err_b;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    remote_node_initiator_if #(.width_p(32), .tag_width_p(3)) ifa ();
    remote_node_initiator_if #(.width_p(32), .tag_width_p(3)) ifb ();

    remote_node_initiator #(.width_p(32), .tag_width_p(3), .num_trans_p(4)) dut_a (
        .clk_i(clk), .reset_i(rst_a), .en_i(en_a), .bus(ifa),
        .outstanding_o(outst_a), .done_o(done_a), .error_o(err_a)
    );

    remote_node_initiator #(.width_p(32), .tag_width_p(3), .num_trans_p(20)) dut_b (
        .clk_i(clk), .reset_i(rst_b), .en_i(en_b), .bus(ifb),
        .outstanding_o(outst_b), .done_o(done_b), .error_o(err_b)
    );

    function automatic logic [31:0] w(input int s, input int t);
        return (32'(s) << 3) | 32'(t & 7);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b1; en_b = 1'b1;
        ifa.yumi_i = 1'b0; ifa.v_i = 1'b1; ifa.data_i = 32'h5;
        ifb.yumi_i = 1'b0; ifb.v_i = 1'b0; ifb.data_i = '0;
        tick(); tick();
        #1;
        chk("rst_v_o", 32'(ifa.v_o), 0);
        chk("rst_yumi_o", 32'(ifa.yumi_o), 0);
        chk("rst_outst", 32'(outst_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_err", 32'(err_a), 0);
        ifa.v_i = 1'b0;

        // in-order echo, one-cycle return latency
        for (int i = 0; i <= 4; i++) begin
            tick();
            rst_a = 1'b0;
            ifa.yumi_i = (i < 4);
            ifa.v_i    = (i > 0);
            ifa.data_i = (i > 0) ? w(i - 1, i - 1) : 32'h0;
            #1;
            if (i < 4) begin
                chk("echo_v_o", 32'(ifa.v_o), 1);
                chk("echo_data", ifa.data_o, w(i, i));
            end else begin
                chk("echo_v_o_end", 32'(ifa.v_o), 0);
                chk("echo_done_early", 32'(done_a), 0);
            end
            if (i > 0) chk("echo_yumi_o", 32'(ifa.yumi_o), 1);
        end
        tick();
        ifa.v_i = 1'b0;
        #1;
        chk("echo_done", 32'(done_a), 1);
        chk("echo_err", 32'(err_a), 0);
        chk("echo_outst", 32'(outst_a), 0);
        chk("echo_v_o_after_done", 32'(ifa.v_o), 0);

        // unknown tag and asynchronous reset mid-run
        tick();
        rst_a = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            rst_a = 1'b0;
            ifa.yumi_i = 1'b1;
            #1;
            chk("mr_v_o", 32'(ifa.v_o), 1);
            chk("mr_data", ifa.data_o, w(i, i));
        end
        tick();
        ifa.yumi_i = 1'b0; ifa.v_i = 1'b1; ifa.data_i = 32'h5;
        #1;
        chk("unk_outst_before", 32'(outst_a), 3);
        chk("unk_yumi_o", 32'(ifa.yumi_o), 1);
        tick();
        ifa.v_i = 1'b0;
        #1;
        chk("unk_err", 32'(err_a), 1);
        chk("unk_outst_after", 32'(outst_a), 3);
        #2 rst_a = 1'b1;
        #1;
        chk("arst_v_o", 32'(ifa.v_o), 0);
        chk("arst_outst", 32'(outst_a), 0);
        chk("arst_done", 32'(done_a), 0);
        chk("arst_err", 32'(err_a), 0);
        tick();
        rst_a = 1'b0;
        #1;
        chk("restart_v_o", 32'(ifa.v_o), 1);
        chk("restart_data", ifa.data_o, 32'h0);

        // reverse-order retirement
        for (int i = 0; i < 8; i++) begin
            tick();
            rst_b = 1'b0;
            ifb.yumi_i = 1'b1;
            #1;
            chk("rev_data", ifb.data_o, w(i, i));
        end
        tick();
        ifb.yumi_i = 1'b0;
        #1;
        chk("rev_full_v_o", 32'(ifb.v_o), 0);
        chk("rev_full_outst", 32'(outst_b), 8);
        for (int k = 0; k < 8; k++) begin
            tick();
            ifb.v_i = 1'b1;
            ifb.data_i = w(7 - k, 7 - k);
            #1;
            chk("rev_ret_v_o", 32'(ifb.v_o), 0);
        end
        tick();
        ifb.v_i = 1'b0;
        #1;
        chk("rev_outst", 32'(outst_b), 0);
        chk("rev_err", 32'(err_b), 0);
        chk("rev_next_v_o", 32'(ifb.v_o), 1);
        chk("rev_next_data", ifb.data_o, w(8, 0));
        chk("rev_done", 32'(done_b), 0);

        // slot stall: tag 0 held while 1..7 return
        ifb.yumi_i = 1'b1;
        for (int i = 1; i < 8; i++) begin
            tick();
            #1;
            chk("stall_issue_data", ifb.data_o, w(8 + i, i));
        end
        for (int k = 1; k < 8; k++) begin
            tick();
            ifb.yumi_i = 1'b0;
            ifb.v_i = 1'b1;
            ifb.data_i = w(8 + k, k);
            #1;
            chk("stall_v_o", 32'(ifb.v_o), 0);
            chk("stall_tag", ifb.data_o & 32'h7, 0);
        end
        tick();
        ifb.data_i = w(8, 0);
        #1;
        chk("stall_free_same_cycle", 32'(ifb.v_o), 0);
        tick();
        ifb.v_i = 1'b0;
        #1;
        chk("stall_release_v_o", 32'(ifb.v_o), 1);
        chk("stall_release_data", ifb.data_o, w(16, 0));
        chk("stall_outst", 32'(outst_b), 0);

        // corrupt return on tag 2
        ifb.yumi_i = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            #1;
            chk("cor_issue_data", ifb.data_o, w(16 + i, i));
        end
        tick();
        ifb.yumi_i = 1'b0;
        #1;
        chk("cor_v_o_exhausted", 32'(ifb.v_o), 0);
        chk("cor_outst", 32'(outst_b), 4);
        for (int t = 0; t < 3; t++) begin
            tick();
            ifb.v_i = 1'b1;
            ifb.data_i = w(16 + t, t) ^ ((t == 2) ? 32'h8000_0000 : 32'h0);
            #1;
        end
        tick();
        ifb.v_i = 1'b0;
        #1;
        chk("cor_err", 32'(err_b), 2);
        chk("cor_outst_left", 32'(outst_b), 1);
        chk("cor_done_early", 32'(done_b), 0);
        tick();
        ifb.v_i = 1'b1;
        ifb.data_i = w(19, 3);
        #1;
        tick();
        ifb.v_i = 1'b0;
        #1;
        chk("cor_done", 32'(done_b), 1);
        chk("cor_err_sticky", 32'(err_b), 2);
        chk("cor_outst_zero", 32'(outst_b), 0);
        tick();
        #1;
        chk("cor_err_still", 32'(err_b), 2);
        chk("cor_done_hold", 32'(done_b), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/remote_node_initiator.md
Name: remote_node_initiator

Overview:
- Initiator side of the remote_node request/return protocol.
- Issues a fixed number of tagged requests toward a remote responder and retires the returns, which may arrive in any order.
- Checks each returned word against its stored copy and reports completion and sticky error status.
- Used as the traffic source and checker in bsg_dataflow reorder testbenches; the RTL is synthesizable.

Parameters:
- width_p, 32, request/return word width; must be > tag_width_p.
- tag_width_p, 3, tag bits; 2^tag_width_p outstanding slots.
- num_trans_p, 64, total requests to issue; must be >= 1.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous active-high reset.
- en_i  in  1  permits issuing new requests.
- v_o  out  1  request valid.
- data_o  out  width_p  request word {seq, tag}; tag is in the low bits.
- yumi_i  in  1  responder has taken the request.
- v_i  in  1  return valid.
- data_i  in  width_p  return word.
- yumi_o  out  1  initiator consumes the return.
- outstanding_o  out  tag_width_p+1  number of busy slots.
- done_o  out  1  all requests issued and all returned.
- error_o  out  2  sticky flags; bit0 unknown tag, bit1 data mismatch.

Behaviour:
- State:
  - busy_r, one bit per slot.
  - mem_r, 2^tag_width_p x width_p copies of issued words.
  - tag_r, next tag.
  - seq_r, width_p-tag_width_p bits, wraps modulo 2^(width_p-tag_width_p).
  - sent_r, requests issued, 0..num_trans_p.
  - outstanding_r, error_r.
- Reset (async): all counters 0, busy_r all 0, error_r 0. mem_r is not reset.
  - Outputs during reset: v_o=0, yumi_o=0, done_o=0, outstanding_o=0, error_o=0.
- Issue rule:
  - v_o = en_i & (sent_r < num_trans_p) & ~busy_r[tag_r], using registered busy_r.
  - data_o = {seq_r, tag_r}.
  - Once v_o is high, data_o holds stable until yumi_i.
  - If en_i drops while v_o is high, v_o drops. No request is lost, because a request is committed only on yumi_i.
- On v_o & yumi_i:
  - mem_r[tag_r] <= data_o; busy_r[tag_r] <= 1.
  - tag_r increments, wrapping from 2^tag_width_p-1 to 0.
  - seq_r and sent_r increment.
- The issue stalls (v_o=0) while the slot at tag_r is busy. Tags are never skipped, so tags are issued strictly round-robin.
- yumi_i while v_o=0 is a protocol violation and is ignored.
- Return rule:
  - yumi_o = v_i (always ready).
  - The return is consumed in the same cycle, with no latency.
- On a consumed return, with rt = data_i[tag_width_p-1:0]:
  - If busy_r[rt]=0: set error_r[0]; no state change.
  - Otherwise: clear busy_r[rt].
    - If data_i != mem_r[rt]: set error_r[1].
- Simultaneous issue and return:
  - Both take effect in the same cycle. outstanding_r is unchanged.
  - A slot freed by a return becomes issuable in the next cycle, not the same cycle.
- outstanding_r:
  - +1 on issue only, -1 on valid-tag return only, unchanged when both occur.
  - Returns with an unknown tag do not decrement it.
- done_o = (sent_r == num_trans_p) & (outstanding_r == 0), registered.
  - It remains high after done; no further requests are issued.
- error_r is sticky until reset.
- Reset asserted mid-operation clears all state immediately. Any returns still in flight afterwards are flagged as unknown tags.

Optional Feature:
- Macro: REMOTE_NODE_INITIATOR_THROTTLE_EN.
- Defined:
  - Adds a 16-bit Fibonacci LFSR with taps 16,14,13,11 and seed 16'hACE1 on reset. It advances every cycle.
  - yumi_o = v_i & lfsr_r[0]. A return is consumed only when lfsr_r[0]=1.
  - This exercises responder hold-off: the responder must hold v/data stable.
- Undefined: yumi_o = v_i, and no LFSR exists.

Test Plan:
- In-order echo: num_trans_p=4, tag_width_p=3, responder returns each word 1 cycle after take -> 4 issues with data_o = {0,0},{1,1},{2,2},{3,3}; done_o=1 one cycle after the last return; error_o=0.
- Reverse order: 8 requests held, then returned tags 7..0 -> during the hold, v_o=0 for the 9th request with outstanding_o=8; all retire; error_o=0.
- Slot stall: tag 0 held while tags 1..7 return -> tag_r stays at 0 and v_o=0 until tag 0 returns; v_o rises the next cycle.
- Corrupt return: flip bit 31 of the word returned for tag 2 -> error_o=2'b10 sticky; slot 2 is freed; done_o still asserts.
- Unknown tag: inject a return with tag 5 while slot 5 is idle -> error_o[0]=1; outstanding_o unchanged.
- Reset mid-run: assert reset_i with outstanding_o=3 -> v_o, outstanding_o, done_o and error_o are all 0 immediately (asynchronous); after release, the issue restarts at tag 0, seq 0.
